// File: rtl/phase_sequencer.sv
// phase_sequencer: variable-length instruction sequencer emitting one-hot datapath phase strobes,
// with fetch handshake, halt/resume, fault detection and a retired-instruction counter.
module phase_sequencer #(
    parameter int FETCH_TIMEOUT = 16,
    parameter int MAX_OPS       = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_ready,
    input  logic [3:0]  num_of_ope,
    input  logic        halt_req,
    input  logic        resume,
    output logic [11:0] phase,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [1:0]  op_index,
    output logic [31:0] retired
);
    typedef enum logic [3:0] {
        RESET_IDLE, FETCH, DECODE, DISPATCH,
        SEL1, EXE1, SEL2, EXE2, SEL3, EXE3,
        COMMIT, HALTED, FAULT
    } state_t;

    state_t      state, state_n;
    logic [7:0]  wait_cnt;
    logic [3:0]  n;
    logic [1:0]  fault_code_n, op_index_n;
    logic [11:0] phase_n;

    always_comb begin
        state_n      = state;
        fault_code_n = fault_code;
        case (state)
            RESET_IDLE: state_n = FETCH;
            FETCH: begin
                if (mem_ready) state_n = DECODE;
                else if (wait_cnt == 8'(FETCH_TIMEOUT - 1)) begin
                    state_n      = FAULT;
                    fault_code_n = 2'd1;
                end
            end
            DECODE:   state_n = DISPATCH;
            DISPATCH: begin
                if (num_of_ope == 4'd0) state_n = COMMIT;
                else if (num_of_ope <= 4'(MAX_OPS)) state_n = SEL1;
                else begin
                    state_n      = FAULT;
                    fault_code_n = 2'd2;
                end
            end
            SEL1:    state_n = EXE1;
            EXE1:    state_n = (n > 4'd1) ? SEL2 : COMMIT;
            SEL2:    state_n = EXE2;
            EXE2:    state_n = (n > 4'd2) ? SEL3 : COMMIT;
            SEL3:    state_n = EXE3;
            EXE3:    state_n = COMMIT;
            COMMIT:  state_n = halt_req ? HALTED : FETCH;
            HALTED:  state_n = resume ? FETCH : HALTED;
            FAULT:   state_n = FAULT;
            default: state_n = RESET_IDLE;
        endcase
        // outputs are decoded from the next state so they register alongside it
        phase_n    = '0;
        op_index_n = '0;
        case (state_n)
            FETCH:   phase_n[0] = 1'b1;
            DECODE:  phase_n[1] = 1'b1;
            SEL1:    begin phase_n[2] = 1'b1; op_index_n = 2'd1; end
            EXE1:    begin phase_n[3] = 1'b1; op_index_n = 2'd1; end
            SEL2:    begin phase_n[4] = 1'b1; op_index_n = 2'd2; end
            EXE2:    begin phase_n[5] = 1'b1; op_index_n = 2'd2; end
            SEL3:    begin phase_n[6] = 1'b1; op_index_n = 2'd3; end
            EXE3:    begin phase_n[7] = 1'b1; op_index_n = 2'd3; end
            COMMIT:  phase_n[11] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RESET_IDLE;
            phase      <= '0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
            fault_code <= '0;
            op_index   <= '0;
            retired    <= '0;
            wait_cnt   <= '0;
            n          <= '0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            busy       <= !(state_n inside {RESET_IDLE, HALTED, FAULT});
            halted     <= state_n == HALTED;
            fault      <= state_n == FAULT;
            fault_code <= fault_code_n;
            op_index   <= op_index_n;
            retired    <= retired + 32'(state == COMMIT);
            wait_cnt   <= (state == FETCH && state_n == FETCH) ? wait_cnt + 8'd1 : 8'd0;
            if (state == DISPATCH) n <= num_of_ope;
        end
    end
endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Replaces the fixed 12-phase ring counter that drives the CPU datapath with a variable-length instruction sequencer.
- Emits the same one-hot phase strobes consumed by fetch, decode, selector, alu, alu_result_selector and the register files.
- Skips select/execute slots an instruction does not use, waits on instruction memory through a ready handshake, and supports halt.
- Raises a fault on illegal micro-op counts or fetch timeout, and counts retired instructions.

Parameters:
- FETCH_TIMEOUT, 16: maximum cycles spent in FETCH without mem_ready before fault; legal range 2..255.
- MAX_OPS, 3: maximum micro-ops per instruction; fixed by the three select/load pairs in the datapath.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_ready  in  1  instruction memory has valid ope this cycle.
- num_of_ope  in  4  micro-op count from decode; valid from the cycle after DECODE.
- halt_req  in  1  stop after the current instruction commits.
- resume  in  1  leave HALTED and start the next fetch.
- phase  out  12  one-hot strobes; bit n corresponds to clock_(n+1).
- busy  out  1  high in every state except RESET_IDLE, HALTED and FAULT.
- halted  out  1  high in HALTED.
- fault  out  1  sticky; high in FAULT.
- fault_code  out  2  0 none, 1 fetch timeout, 2 illegal num_of_ope.
- op_index  out  2  current micro-op 1..3 during SELk/EXEk, else 0.
- retired  out  32  count of committed instructions.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-instruction) forces: state RESET_IDLE, phase=0, busy=0, halted=0, fault=0, fault_code=0, op_index=0, retired=0, wait counter=0.
- States and the phase value each drives:
  - RESET_IDLE: phase=0.
  - FETCH: phase[0].
  - DECODE: phase[1].
  - DISPATCH: phase=0.
  - SEL1/EXE1: phase[2]/phase[3].
  - SEL2/EXE2: phase[4]/phase[5].
  - SEL3/EXE3: phase[6]/phase[7].
  - COMMIT: phase[11].
  - HALTED and FAULT: phase=0.
  - phase[10:8] are never asserted.
- RESET_IDLE -> FETCH on the first rising edge with reset low.
- FETCH:
  - mem_ready=1 -> DECODE next cycle.
  - Otherwise the wait counter increments.
  - When the counter reaches FETCH_TIMEOUT-1 with mem_ready still low -> FAULT with fault_code=1.
  - The counter clears on leaving FETCH.
- DECODE lasts exactly 1 cycle, then -> DISPATCH.
- DISPATCH latches num_of_ope into an internal count N:
  - N=0 -> COMMIT.
  - 1..MAX_OPS -> SEL1.
  - N>MAX_OPS -> FAULT with fault_code=2.
- SELk -> EXEk, always 1 cycle each.
- EXEk -> SEL(k+1) if k<N, else -> COMMIT.
- The value on num_of_ope after DISPATCH is ignored until the next DISPATCH.
- COMMIT lasts 1 cycle; retired increments on leaving COMMIT and wraps 0xFFFFFFFF -> 0.
- After COMMIT: halt_req=1 (sampled in COMMIT) -> HALTED; else -> FETCH.
- halt_req outside COMMIT is not latched; it must be held until COMMIT.
- HALTED: halted=1, busy=0; resume=1 -> FETCH next cycle.
- FAULT: absorbing state; left only by reset; resume is ignored.
- Cycle counts per instruction with mem_ready already high: 4 + 2N (FETCH, DECODE, DISPATCH, N×2, COMMIT).
- Exactly one phase bit or none is high in any cycle.
- op_index = k in SELk and EXEk.

Test Plan:
- Reset release, mem_ready=1, num_of_ope=2 constant -> phase sequence 001,002,000,004,008,010,020,800, repeating every 8 cycles; retired=1 after the first COMMIT and 2 after the second.
- num_of_ope=0 -> sequence 001,002,000,800; retired increments every 4 cycles; op_index stays 0.
- mem_ready low for 5 cycles then high, FETCH_TIMEOUT=16 -> phase[0] held for 6 cycles, then DECODE; no fault.
- mem_ready held low -> after 16 FETCH cycles fault=1, fault_code=1, phase=0, busy=0; resume has no effect; reset clears all.
- num_of_ope=5 at DISPATCH -> FAULT with fault_code=2 with no SEL phase issued.
- halt_req raised during EXE1 of a 3-op instruction and held -> EXE2..EXE3 and COMMIT complete, then halted=1, retired+1; resume pulse -> phase=001 next cycle.
- Reset asserted asynchronously mid-EXE2 -> phase=0 and retired=0 immediately without waiting for a clock edge; restart at FETCH on the first edge after release.
